mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS core, directly downstream of the general-purpose register file.
- Consumes the two register-file read-port values (rs, rt) for MULT/MULTU/DIV/DIVU.
- Holds the architectural HI and LO registers, which MFHI/MFLO read and MTHI/MTLO write.
- Multi-cycle: asserts o_busy so the pipeline stalls any dependent MDU instruction.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH
CNT_WIDTH, 6, iteration counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  launch operation selected by i_op; sampled only when o_busy=0
i_op  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU
i_opa  input  DATA_WIDTH  rs value (multiplicand/dividend), from register-file read port A
i_opb  input  DATA_WIDTH  rt value (multiplier/divisor), from register-file read port B
i_hi_we  input  1  MTHI write enable
i_lo_we  input  1  MTLO write enable
i_wdata  input  DATA_WIDTH  MTHI/MTLO data
o_hi  output  DATA_WIDTH  HI register
o_lo  output  DATA_WIDTH  LO register
o_busy  output  1  operation in progress
o_done  output  1  one-cycle pulse when HI/LO were just updated by an operation

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; o_hi=0, o_lo=0, o_busy=0, o_done=0; counter and internal datapath registers=0.
  - Reset asserted mid-operation aborts it. No partial result reaches HI/LO.
- States:
  - IDLE -> MUL (i_start, op 0/1) or DIV (i_start, op 2/3).
  - MUL/DIV -> FIX after DATA_WIDTH iterations.
  - FIX -> IDLE.
- Launch (edge E0, i_start=1, o_busy=0):
  - Latch |opa| and |opb| for signed ops (raw values for unsigned ops).
  - Latch result-sign flags: product/quotient sign = a[31]^b[31]; remainder sign = a[31]. Signed ops only.
  - Latch the divide-by-zero flag (opb==0); clear the counter.
- MUL: one shift-add step per cycle on a 2*DATA_WIDTH accumulator.
- DIV: one restoring shift-subtract step per cycle, 33-bit partial remainder.
- Absolute values use DATA_WIDTH+1 bits, so 0x80000000 is handled exactly.
- FIX (edge E33):
  - Apply two's-complement sign correction, then write HI/LO.
  - MUL: HI = upper product, LO = lower product.
  - DIV: LO = quotient, HI = remainder.
  - Divide by zero (either signedness): HI = i_opa as latched, LO = all ones.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, no trap.
- Timing:
  - o_busy=1 from after E0 until after E33 (33 cycles).
  - After E33: o_busy=0, o_done=1 for exactly one cycle, new HI/LO visible.
  - A new i_start is accepted in that same cycle.
- o_hi/o_lo hold their previous values throughout an operation; no intermediate values are visible.
- MTHI/MTLO:
  - With o_busy=0: HI/LO are written at the next edge and visible the following cycle.
  - i_hi_we and i_lo_we may both be asserted; both registers take i_wdata.
- Conflicts:
  - i_start while o_busy=1: ignored.
  - i_hi_we/i_lo_we while o_busy=1: ignored. The pipeline must stall on o_busy.
  - i_start together with a write enable while idle: i_start wins and the write is dropped.
- Operands are sampled only at launch. i_opa/i_opb may change freely afterwards.

Decomposition:
- Shared package mips_defs:
  - MDU op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU).
  - DATA_WIDTH default.
  - MDU state encoding (IDLE, MUL, DIV, FIX).
- Single module: control FSM plus shared shift datapath. No sub-module is natural; the sign-magnitude conversion is inline.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> o_done exactly 33 cycles after launch, HI=0xFFFFFFFE, LO=0x00000001; o_busy high for exactly 33 cycles.
- MULT 0xFFFFFFFD(-3)*0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 0x1234/0 -> HI=0x1234, LO=0xFFFFFFFF.
- Busy and write conflicts:
  - While busy, pulse i_start with new operands and i_hi_we with 0xAAAA -> both ignored; the final result matches the original operation.
  - Idle i_lo_we with 0x55 -> o_lo=0x55 the next cycle.
  - Idle i_start together with i_hi_we -> the operation runs and HI is not written by MTHI.
- Mid-operation reset:
  - Assert i_rst_n=0 at iteration 10 -> o_busy, o_done, o_hi, o_lo all 0 immediately.
  - After release, MULTU 6*7 -> LO=42, HI=0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS core definitions used by the HI/LO multiply/divide unit.
// Holds the MDU operation encodings, datapath width defaults, the MDU
// control-state encoding and the per-operation flag bundle that is
// latched when an operation is launched.
package mips_defs;

    localparam int unsigned MDU_DATA_WIDTH = 32;
    localparam int unsigned MDU_CNT_WIDTH  = 6;
    localparam int unsigned MDU_OP_WIDTH   = 2;

    // MDU operation encodings as presented on i_op
    typedef enum logic [MDU_OP_WIDTH-1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    // MDU control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    // Per-operation flags captured at launch and consumed in the fix-up step
    typedef struct packed {
        logic is_div;   // divide (1) or multiply (0)
        logic neg_q;    // negate product / quotient
        logic neg_r;    // negate remainder
        logic dbz;      // divisor was zero
    } mdu_flags_t;

    // Even encodings are the signed variants (MULT, DIV)
    function automatic logic op_is_signed(input logic [MDU_OP_WIDTH-1:0] op);
        return ~op[0];
    endfunction

    // Upper encoding bit selects divide
    function automatic logic op_is_div(input logic [MDU_OP_WIDTH-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline-to-MDU interface.
// master : pipeline side, drives launch/MTHI/MTLO requests, observes HI/LO/busy/done
// slave  : MDU side
//   i_start/i_op/i_opa/i_opb : launch request with rs/rt operands
//   i_hi_we/i_lo_we/i_wdata  : MTHI/MTLO writes
//   o_hi/o_lo                : architectural HI/LO
//   o_busy/o_done            : operation in flight / one-cycle result pulse
interface mult_div_unit_if #(
    parameter int unsigned DATA_WIDTH = mips_defs::MDU_DATA_WIDTH
) ();

    logic                                i_start;
    logic [mips_defs::MDU_OP_WIDTH-1:0]  i_op;
    logic [DATA_WIDTH-1:0]               i_opa;
    logic [DATA_WIDTH-1:0]               i_opb;
    logic                                i_hi_we;
    logic                                i_lo_we;
    logic [DATA_WIDTH-1:0]               i_wdata;
    logic [DATA_WIDTH-1:0]               o_hi;
    logic [DATA_WIDTH-1:0]               o_lo;
    logic                                o_busy;
    logic                                o_done;

    modport master (
        output i_start, i_op, i_opa, i_opb, i_hi_we, i_lo_we, i_wdata,
        input  o_hi, o_lo, o_busy, o_done
    );

    modport slave (
        input  i_start, i_op, i_opa, i_opb, i_hi_we, i_lo_we, i_wdata,
        output o_hi, o_lo, o_busy, o_done
    );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : mult_div_unit_if.slave (launch, MTHI/MTLO, HI/LO, busy, done)
// A launch latches operand magnitudes and sign flags, runs DATA_WIDTH
// shift-add (MUL) or restoring shift-subtract (DIV) steps on a shared
// accumulator, then applies sign correction and writes HI/LO in one FIX cycle.
module mult_div_unit
    import mips_defs::*;
#(
    parameter int unsigned DATA_WIDTH = MDU_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = MDU_CNT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    mult_div_unit_if.slave   bus
);

    localparam int unsigned EXT_W  = DATA_WIDTH + 1;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    mdu_state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [EXT_W-1:0]        opr_q;      // multiplicand (MUL) or divisor (DIV) magnitude
    logic [DATA_WIDTH-1:0]   acc_hi_q;   // upper product / partial remainder
    logic [DATA_WIDTH-1:0]   acc_lo_q;   // multiplier bits / dividend-then-quotient bits
    logic [DATA_WIDTH-1:0]   opa_q;      // raw rs, needed for divide-by-zero HI
    mdu_flags_t              flags_q;
    logic [DATA_WIDTH-1:0]   hi_q, lo_q;
    logic                    busy_q, done_q;

    logic                    launch, step, fix, mt_hi, mt_lo;
    logic                    busy_d, done_d;

    logic                    op_signed, a_neg, b_neg;
    logic [EXT_W-1:0]        a_mag, b_mag;
    mdu_flags_t              launch_flags;

    logic [EXT_W-1:0]        mul_sum;
    logic [EXT_W-1:0]        div_shift;
    logic                    div_ge;
    logic [DATA_WIDTH-1:0]   acc_hi_n, acc_lo_n;

    logic [PROD_W-1:0]       prod_mag, prod_res;
    logic [DATA_WIDTH-1:0]   hi_fix, lo_fix;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control strobes; launch has priority over MTHI/MTLO
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    launch  = 1'b1;
                    state_d = op_is_div(bus.i_op) ? ST_DIV : ST_MUL;
                end else begin
                    mt_hi = bus.i_hi_we;
                    mt_lo = bus.i_lo_we;
                end
            end
            ST_MUL, ST_DIV: begin
                step = 1'b1;
                if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                fix     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = fix;
    end

    // Operand magnitudes in DATA_WIDTH+1 bits so the most negative value is exact
    always_comb begin
        op_signed = op_is_signed(bus.i_op);
        a_neg     = op_signed & bus.i_opa[DATA_WIDTH-1];
        b_neg     = op_signed & bus.i_opb[DATA_WIDTH-1];
        a_mag     = a_neg ? (EXT_W'(0) - {1'b1, bus.i_opa}) : {1'b0, bus.i_opa};
        b_mag     = b_neg ? (EXT_W'(0) - {1'b1, bus.i_opb}) : {1'b0, bus.i_opb};
        launch_flags.is_div = op_is_div(bus.i_op);
        launch_flags.neg_q  = a_neg ^ b_neg;
        launch_flags.neg_r  = a_neg;
        launch_flags.dbz    = (bus.i_opb == '0);
    end

    // One iteration of shift-add or restoring shift-subtract
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? opr_q : EXT_W'(0));
        div_shift = {acc_hi_q, acc_lo_q[DATA_WIDTH-1]};
        div_ge    = (div_shift >= opr_q);
        if (state_q == ST_DIV) begin
            acc_hi_n = div_ge ? DATA_WIDTH'(div_shift - opr_q) : div_shift[DATA_WIDTH-1:0];
            acc_lo_n = {acc_lo_q[DATA_WIDTH-2:0], div_ge};
        end else begin
            acc_hi_n = mul_sum[EXT_W-1:1];
            acc_lo_n = {mul_sum[0], acc_lo_q[DATA_WIDTH-1:1]};
        end
    end

    // Sign correction and special cases for the final HI/LO write
    always_comb begin
        prod_mag = {acc_hi_q, acc_lo_q};
        prod_res = flags_q.neg_q ? (PROD_W'(0) - prod_mag) : prod_mag;
        hi_fix   = prod_res[PROD_W-1:DATA_WIDTH];
        lo_fix   = prod_res[DATA_WIDTH-1:0];
        if (flags_q.is_div) begin
            if (flags_q.dbz) begin
                hi_fix = opa_q;
                lo_fix = '1;
            end else begin
                lo_fix = flags_q.neg_q ? (DATA_WIDTH'(0) - acc_lo_q) : acc_lo_q;
                hi_fix = flags_q.neg_r ? (DATA_WIDTH'(0) - acc_hi_q) : acc_hi_q;
            end
        end
    end

    // Datapath, HI/LO and status registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            opr_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opa_q    <= '0;
            flags_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (launch) begin
                cnt_q    <= '0;
                opr_q    <= launch_flags.is_div ? b_mag : a_mag;
                acc_hi_q <= '0;
                acc_lo_q <= launch_flags.is_div ? a_mag[DATA_WIDTH-1:0] : b_mag[DATA_WIDTH-1:0];
                opa_q    <= bus.i_opa;
                flags_q  <= launch_flags;
            end else if (step) begin
                cnt_q    <= cnt_q + CNT_WIDTH'(1);
                acc_hi_q <= acc_hi_n;
                acc_lo_q <= acc_lo_n;
            end
            if (fix) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end else begin
                if (mt_hi) hi_q <= bus.i_wdata;
                if (mt_lo) lo_q <= bus.i_wdata;
            end
        end
    end

    assign bus.o_hi   = hi_q;
    assign bus.o_lo   = lo_q;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: reset state, signed and
// unsigned multiply/divide results, latency and busy width, special divide
// cases, busy/idle write conflicts and reset in the middle of an operation.
module tb_mult_div_unit;
    import mips_defs::*;

    logic i_clk;
    logic i_rst_n;
    int   n_checks;
    int   n_fail;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mult_div_unit_if #(.DATA_WIDTH(32)) mdu_bus ();

    mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (mdu_bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op, optionally injecting a busy-time conflict or an idle MTHI at launch
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string tag, input bit inject, input bit start_we);
        int edges;
        int busy_cnt;
        @(negedge i_clk);
        mdu_bus.i_start = 1'b1;
        mdu_bus.i_op    = op;
        mdu_bus.i_opa   = a;
        mdu_bus.i_opb   = b;
        if (start_we) begin
            mdu_bus.i_hi_we = 1'b1;
            mdu_bus.i_wdata = 32'h0000DEAD;
        end
        @(negedge i_clk);
        mdu_bus.i_start = 1'b0;
        mdu_bus.i_hi_we = 1'b0;
        mdu_bus.i_opa   = ~a;
        mdu_bus.i_opb   = b ^ 32'h5A5A5A5A;
        edges    = 0;
        busy_cnt = 0;
        chk({tag, "_hi_hold0"}, mdu_bus.o_hi, model_hi);
        chk({tag, "_lo_hold0"}, mdu_bus.o_lo, model_lo);
        while (mdu_bus.o_done !== 1'b1 && edges < 100) begin
            if (mdu_bus.o_busy === 1'b1) busy_cnt++;
            if (inject && edges == 5) begin
                mdu_bus.i_start = 1'b1;
                mdu_bus.i_op    = MDU_DIVU;
                mdu_bus.i_opa   = 32'd7;
                mdu_bus.i_opb   = 32'd3;
                mdu_bus.i_hi_we = 1'b1;
                mdu_bus.i_wdata = 32'h0000AAAA;
            end else if (inject && edges == 6) begin
                mdu_bus.i_start = 1'b0;
                mdu_bus.i_hi_we = 1'b0;
            end
            if (edges == 16) begin
                chk({tag, "_hi_hold16"}, mdu_bus.o_hi, model_hi);
                chk({tag, "_lo_hold16"}, mdu_bus.o_lo, model_lo);
            end
            @(negedge i_clk);
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'd33);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        chk({tag, "_busy_low_at_done"}, 32'(mdu_bus.o_busy), 32'd0);
        chk({tag, "_hi"}, mdu_bus.o_hi, exp_hi);
        chk({tag, "_lo"}, mdu_bus.o_lo, exp_lo);
        model_hi = exp_hi;
        model_lo = exp_lo;
        @(negedge i_clk);
        chk({tag, "_done_pulse"}, 32'(mdu_bus.o_done), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_hi = 32'h0;
        model_lo = 32'h0;
        i_clk    = 1'b0;
        i_rst_n  = 1'b0;
        mdu_bus.i_start = 1'b0;
        mdu_bus.i_op    = MDU_MULT;
        mdu_bus.i_opa   = 32'h0;
        mdu_bus.i_opb   = 32'h0;
        mdu_bus.i_hi_we = 1'b0;
        mdu_bus.i_lo_we = 1'b0;
        mdu_bus.i_wdata = 32'h0;

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("rst_busy", 32'(mdu_bus.o_busy), 32'd0);
        chk("rst_done", 32'(mdu_bus.o_done), 32'd0);
        chk("rst_hi", mdu_bus.o_hi, 32'h0);
        chk("rst_lo", mdu_bus.o_lo, 32'h0);
        i_rst_n = 1'b1;

        // Multiply
        run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", 1'b0, 1'b0);
        run_op(MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7", 1'b0, 1'b0);
        run_op(MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minsq", 1'b0, 1'b0);

        // Divide
        run_op(MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2", 1'b0, 1'b0);
        run_op(MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100by7", 1'b0, 1'b0);
        run_op(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf", 1'b0, 1'b0);
        run_op(MDU_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, "divu_by0", 1'b0, 1'b0);

        // Busy conflict: new start and MTHI mid-operation are ignored
        run_op(MDU_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "busy_conflict", 1'b1, 1'b0);

        // Idle MTLO
        @(negedge i_clk);
        mdu_bus.i_lo_we = 1'b1;
        mdu_bus.i_wdata = 32'h00000055;
        @(negedge i_clk);
        mdu_bus.i_lo_we = 1'b0;
        chk("mtlo_lo", mdu_bus.o_lo, 32'h00000055);
        chk("mtlo_hi_kept", mdu_bus.o_hi, 32'h00000001);
        model_lo = 32'h00000055;

        // Idle MTHI and MTLO together
        mdu_bus.i_hi_we = 1'b1;
        mdu_bus.i_lo_we = 1'b1;
        mdu_bus.i_wdata = 32'h00000077;
        @(negedge i_clk);
        mdu_bus.i_hi_we = 1'b0;
        mdu_bus.i_lo_we = 1'b0;
        chk("mt_both_hi", mdu_bus.o_hi, 32'h00000077);
        chk("mt_both_lo", mdu_bus.o_lo, 32'h00000077);
        model_hi = 32'h00000077;
        model_lo = 32'h00000077;

        // Start wins over a simultaneous MTHI
        run_op(MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "start_vs_mthi", 1'b0, 1'b1);

        // Reset at iteration 10 aborts the operation
        @(negedge i_clk);
        mdu_bus.i_start = 1'b1;
        mdu_bus.i_op    = MDU_MULTU;
        mdu_bus.i_opa   = 32'd5;
        mdu_bus.i_opb   = 32'd5;
        @(negedge i_clk);
        mdu_bus.i_start = 1'b0;
        repeat (10) @(negedge i_clk);
        chk("midrst_busy_before", 32'(mdu_bus.o_busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(mdu_bus.o_busy), 32'd0);
        chk("midrst_done", 32'(mdu_bus.o_done), 32'd0);
        chk("midrst_hi", mdu_bus.o_hi, 32'h0);
        chk("midrst_lo", mdu_bus.o_lo, 32'h0);
        model_hi = 32'h0;
        model_lo = 32'h0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_op(MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "post_rst_multu", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
